// File: rtl/uart_pkg.sv
// Shared types and constants for the UART character sender.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: one-cycle bitTick when the count reaches CLKS_PER_BIT-1,
// held at zero while disabled and cleared by restart when a frame is accepted.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic bitTick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last_s;

  assign at_last_s = (cnt_q == LAST);
  assign bitTick   = enable && at_last_s;

  // Next count: restart and idle both park the counter at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (!enable) begin
      cnt_d = '0;
    end else if (at_last_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_char_sender.sv
// Serializes one latched character per startSend onto a UART TX line and
// reports frame completion with a one-cycle sendDone pulse.
module uart_char_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startSend,
  input  logic [DATA_BITS-1:0] charIn,
  output logic                 tx,
  output logic                 busy,
  output logic                 sendDone,
  output logic [7:0]           charsSent
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 send_done_q, send_done_d;
  logic [7:0]           chars_sent_q, chars_sent_d;
  logic                 accept_s;
  logic                 bit_tick_s;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q != IDLE),
    .restart(accept_s),
    .bitTick(bit_tick_s)
  );

  // Frame sequencing: next state, shift register and bit index.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_d     = par_q;
    accept_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (startSend) begin
          accept_s  = 1'b1;
          shift_d   = charIn;
          par_d     = even_parity(charIn);
          bit_idx_d = 3'd0;
          state_d   = START;
        end else begin
          state_d   = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_tick_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values; tx follows the current state so the start bit lands one
  // cycle after acceptance.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d      = (state_d != IDLE);
    send_done_d = (state_q == STOP) && bit_tick_s;
    if (send_done_d && (chars_sent_q != 8'hFF)) begin
      chars_sent_d = chars_sent_q + 8'd1;
    end else begin
      chars_sent_d = chars_sent_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= 3'd0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      send_done_q  <= 1'b0;
      chars_sent_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      send_done_q  <= send_done_d;
      chars_sent_q <= chars_sent_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign sendDone  = send_done_q;
  assign charsSent = chars_sent_q;

endmodule

// File: tb/tb_uart_char_sender.sv
// Directed bench: dut_a without parity, dut_b with even parity, both at 4 clocks per bit.
module tb_uart_char_sender;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       start_a, start_b;
  logic [7:0] char_a, char_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_char_sender #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .startSend(start_a), .charIn(char_a),
    .tx(tx_a), .busy(busy_a), .sendDone(done_a), .charsSent(cnt_a)
  );

  uart_char_sender #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .startSend(start_b), .charIn(char_b),
    .tx(tx_b), .busy(busy_b), .sendDone(done_b), .charsSent(cnt_b)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accept edge. mode 1: pulse startSend with 8'h55 mid-frame;
  // mode 2: switch charIn to 8'h42 mid-frame while startSend stays high.
  task automatic check_frame(input bit p, input logic [7:0] b, input int mode);
    logic [10:0] fr;
    int          segs;
    logic        t, bz, dn;
    segs     = p ? 11 : 10;
    fr       = '1;
    fr[0]    = 1'b0;
    fr[8:1]  = b;
    if (p) fr[9] = ^b;
    for (int k = 1; k <= segs * 4; k++) begin
      @(posedge clk); #1;
      if (mode == 1 && k == 16) begin start_a = 1'b1; char_a = 8'h55; end
      if (mode == 1 && k == 17) start_a = 1'b0;
      if (mode == 2 && k == 16) char_a = 8'h42;
      t  = p ? tx_b   : tx_a;
      bz = p ? busy_b : busy_a;
      dn = p ? done_b : done_a;
      if (k < segs * 4) begin
        check1("frame_tx", t, fr[(k-1)/4]);
        check1("frame_busy", bz, 1'b1);
        check1("frame_no_done", dn, 1'b0);
      end else begin
        check1("end_tx_high", t, 1'b1);
        check1("end_busy_low", bz, 1'b0);
        check1("end_done_pulse", dn, 1'b1);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    char_a = 8'h00; char_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    check1("rst_tx_a", tx_a, 1'b1);
    check1("rst_busy_a", busy_a, 1'b0);
    check1("rst_tx_b", tx_b, 1'b1);
    check8("rst_cnt_b", cnt_b, 8'd0);

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check1("idle_tx_a", tx_a, 1'b1);
      check1("idle_busy_a", busy_a, 1'b0);
      check1("idle_done_a", done_a, 1'b0);
      check8("idle_cnt_a", cnt_a, 8'd0);
      check1("idle_tx_b", tx_b, 1'b1);
      check1("idle_done_b", done_b, 1'b0);
    end

    // Reset during data bit 3 on dut_b
    start_b = 1'b1; char_b = 8'h3C;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check1("pre_abort_busy", busy_b, 1'b1);
    check1("pre_abort_tx_bit3", tx_b, 1'b1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check1("abort_tx", tx_b, 1'b1);
    check1("abort_busy", busy_b, 1'b0);
    check1("abort_done", done_b, 1'b0);
    check8("abort_cnt", cnt_b, 8'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check1("post_abort_tx", tx_b, 1'b1);
      check1("post_abort_done", done_b, 1'b0);
    end

    // Parity frames on dut_b
    start_b = 1'b1; char_b = 8'h07;
    @(posedge clk); #1;
    start_b = 1'b0; char_b = 8'hFF;
    check_frame(1'b1, 8'h07, 0);
    check8("par07_cnt", cnt_b, 8'd1);
    start_b = 1'b1; char_b = 8'h03;
    @(posedge clk); #1;
    start_b = 1'b0;
    check1("par03_done_cleared", done_b, 1'b0);
    check_frame(1'b1, 8'h03, 0);
    check8("par03_cnt", cnt_b, 8'd2);

    // Single frame on dut_a
    start_a = 1'b1; char_a = 8'hA5;
    @(posedge clk); #1;
    start_a = 1'b0; char_a = 8'h00;
    check_frame(1'b0, 8'hA5, 0);
    check8("a5_cnt", cnt_a, 8'd1);
    @(posedge clk); #1;
    check1("a5_done_one_cycle", done_a, 1'b0);
    check1("a5_idle_tx", tx_a, 1'b1);

    // startSend while busy is ignored
    start_a = 1'b1; char_a = 8'hA5;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_frame(1'b0, 8'hA5, 1);
    check8("ignore_cnt", cnt_a, 8'd2);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check1("ignore_no_queue_busy", busy_a, 1'b0);
      check1("ignore_no_second_done", done_a, 1'b0);
    end

    // Back-to-back frames with startSend held high
    start_a = 1'b1; char_a = 8'h41;
    @(posedge clk); #1;
    check_frame(1'b0, 8'h41, 2);
    check8("b2b_cnt1", cnt_a, 8'd3);
    @(posedge clk); #1;
    start_a = 1'b0;
    check1("b2b_accept_busy", busy_a, 1'b1);
    check1("b2b_done_cleared", done_a, 1'b0);
    check_frame(1'b0, 8'h42, 0);
    check8("b2b_cnt2", cnt_a, 8'd4);
    @(posedge clk); #1;
    check1("b2b_final_idle", busy_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
